adder_accumulator: RTL and testbench
====================================

Name: adder_accumulator

Overview:
- Sequential stage wrapped around the existing 4-bit combinational Adder (ports x, y, is_sub, sum, co).
- Accepts an operand/opcode stream over a valid/ready handshake and drives the Adder from a registered 4-bit accumulator.
- Registers sum, carry and status flags, then presents each result downstream over a second valid/ready handshake.
- Forms the stateful ALU stage of the lab datapath, with one result per accepted op.

Parameters:
- STICKY_OVF, 1: when 1, the ovf_sticky output latches any overflow until a CLEAR/LOAD op or reset; when 0, ovf_sticky mirrors the per-op overflow.
- CNT_W, 8: width of the accepted-op counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  block can accept an op this cycle.
- in_data  in  4  operand.
- in_op  in  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- acc  out  4  accumulator value (the result).
- carry  out  1  Adder co of the last ADD/SUB; 0 for LOAD/CLEAR.
- zero  out  1  acc == 0.
- overflow  out  1  signed (two's complement) overflow of the last op.
- ovf_sticky  out  1  sticky overflow (see STICKY_OVF).
- op_count  out  CNT_W  number of accepted ops, wraps modulo 2^CNT_W.

Behaviour:
Reset:
- Asynchronous on rst_n low, effective immediately.
- acc=0, carry=0, zero=1, overflow=0, ovf_sticky=0, op_count=0, out_valid=0, state=EMPTY.
- Reset asserted mid-handshake drops out_valid at once; the pending result is discarded.

Adder connection:
- x=acc_reg, y=in_data, is_sub=(in_op==SUB).
- co is the carry-out of x+y for ADD and of x+~y+1 for SUB, so co=1 on SUB means no borrow.

Handshake:
- in_ready = !out_valid || out_ready (one-deep output register; back-to-back ops at full rate when out_ready=1).
- An op is accepted on a rising edge when in_valid && in_ready.
- Result appears with 1-cycle latency: out_valid=1 in the cycle after acceptance.
- While out_valid && !out_ready: acc and all flags hold stable, in_ready=0, and in_data/in_op are ignored.
- in_valid without in_ready has no effect.

FSM:
- EMPTY: out_valid=0. On accept go to FULL.
- FULL: out_valid=1.
  - out_ready && in_valid: stay FULL with the new result.
  - out_ready && !in_valid: go to EMPTY.
  - !out_ready: stay FULL and hold.

Op effects (at accept):
- LOAD: acc=in_data, carry=0, overflow=0.
- ADD: acc=sum, carry=co, overflow=(acc[3]==in_data[3]) && (sum[3]!=acc[3]).
- SUB: acc=sum, carry=co, overflow=(acc[3]!=in_data[3]) && (sum[3]!=acc[3]).
- CLEAR: acc=0, carry=0, overflow=0; in_data ignored.
- For all ops: zero is computed from the new acc, and op_count increments by 1, wrapping from 2^CNT_W-1 to 0.

Flags:
- ovf_sticky (STICKY_OVF=1) is set by any accepted op with overflow=1 and cleared by LOAD or CLEAR.
- Results wrap modulo 16; there is no saturation.

Decomposition:
- Shared package adder_pkg: opcode enum op_e (OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR), DATA_W=4, state enum st_e (EMPTY, FULL).
- Single sub-module: the existing Adder, instantiated unchanged as u_adder.
- FSM, accumulator and flag logic live in adder_accumulator.

Test Plan:
- Reset, then LOAD 5, ADD 3 with out_ready=1 -> acc=8, carry=0, overflow=1, zero=0, ovf_sticky=1, op_count=2.
- LOAD 8, SUB 8 -> acc=0, carry=1, zero=1, overflow=0; a following CLEAR drops ovf_sticky to 0.
- LOAD 1, ADD 15 -> acc=0, carry=1, zero=1, overflow=0; LOAD 4, SUB 7 -> acc=13 (-3), carry=0, overflow=0.
- Backpressure: out_ready=0 for 3 cycles after ADD result 9 -> acc=9 held, in_ready=0, in_op ignored; when out_ready=1, the next op is accepted the same cycle.
- Back-to-back: 4 ADD 1 ops on consecutive cycles from acc=0 -> out_valid is continuously 1 and acc reads 1, 2, 3, 4; op_count wraps 255->0 on the 256th op.
- Assert rst_n low mid-FULL -> out_valid=0 and acc=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared widths, opcodes and handshake states for the accumulator stage
package adder_pkg;
  localparam int DATA_W = 4;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLEAR = 2'b11} op_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} st_e;
endpackage

// File: rtl/adder_accumulator_adder.sv
// Adder: 4-bit add/subtract; on subtract co=1 means no borrow
module Adder
  import adder_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              is_sub,
  output logic [DATA_W-1:0] sum,
  output logic              co
);
  assign {co, sum} = {1'b0, x} + {1'b0, is_sub ? ~y : y} + {{DATA_W{1'b0}}, is_sub};
endmodule

// File: rtl/adder_accumulator.sv
// adder_accumulator: handshaked accumulator stage around Adder with registered flags
module adder_accumulator
  import adder_pkg::*;
#(
  parameter bit STICKY_OVF = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              zero,
  output logic              overflow,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  op_count
);
  st_e state_q, state_d;
  op_e op;
  logic [DATA_W-1:0] acc_q, acc_d, sum;
  logic carry_q, carry_d, ovf_q, ovf_d, sticky_q, sticky_d, co, accept, ld_clr;
  logic [CNT_W-1:0] cnt_q;
  assign op = op_e'(in_op);
  Adder u_adder (.x(acc_q), .y(in_data), .is_sub(op == OP_SUB), .sum(sum), .co(co));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? FULL : (out_ready ? EMPTY : state_q);
  end
  always_comb begin
    out_valid = state_q == FULL;
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
  end
  always_comb begin
    ld_clr   = op == OP_LOAD || op == OP_CLEAR;
    acc_d    = op == OP_LOAD ? in_data : op == OP_CLEAR ? '0 : sum;
    carry_d  = !ld_clr && co;
    ovf_d    = op == OP_ADD ? (acc_q[DATA_W-1] == in_data[DATA_W-1]) && (sum[DATA_W-1] != acc_q[DATA_W-1]) :
               op == OP_SUB ? (acc_q[DATA_W-1] != in_data[DATA_W-1]) && (sum[DATA_W-1] != acc_q[DATA_W-1]) : 1'b0;
    sticky_d = STICKY_OVF ? !ld_clr && (sticky_q || ovf_d) : ovf_d;
  end
  // results and flags only move on an accepted op, so they hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end
  assign acc        = acc_q;
  assign carry      = carry_q;
  assign zero       = acc_q == '0;
  assign overflow   = ovf_q;
  assign ovf_sticky = sticky_q;
  assign op_count   = cnt_q;
endmodule

// File: tb/tb_adder_accumulator.sv
// tb_adder_accumulator: directed ops with hand-computed results checked by a queue-based monitor
module tb_adder_accumulator;
  typedef struct packed {
    logic [3:0] a;
    logic       c, z, o, s;
    logic [7:0] n;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_data = '0;
  logic [1:0] in_op = '0;
  logic in_ready, out_valid, carry, zero, overflow, ovf_sticky;
  logic [3:0] acc;
  logic [7:0] op_count, cnt_m = '0;
  int total = 0, bad = 0;
  exp_t q[$];
  adder_accumulator #(.STICKY_OVF(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .carry(carry),
    .zero(zero), .overflow(overflow), .ovf_sticky(ovf_sticky), .op_count(op_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got acc=%0d expected no result", acc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("acc", 8'(acc), 8'(e.a));
        check("carry", 8'(carry), 8'(e.c));
        check("zero", 8'(zero), 8'(e.z));
        check("overflow", 8'(overflow), 8'(e.o));
        check("ovf_sticky", 8'(ovf_sticky), 8'(e.s));
        check("op_count", op_count, e.n);
      end
    end
  end
  task automatic push(input logic [3:0] ea, input logic ec, input logic eo, input logic es);
    cnt_m++;
    q.push_back({ea, ec, ea == 4'd0, eo, es, cnt_m});
  endtask
  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [3:0] ea,
                      input logic ec, input logic eo, input logic es);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else push(ea, ec, eo, es);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  initial begin
    #12;
    check("reset_acc", 8'(acc), 8'd0);
    check("reset_zero", 8'(zero), 8'd1);
    check("reset_out_valid", 8'(out_valid), 8'd0);
    check("reset_op_count", op_count, 8'd0);
    check("reset_sticky", 8'(ovf_sticky), 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // LOAD/ADD/SUB/CLEAR with sticky overflow behaviour
    send(2'b00, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    send(2'b01, 4'd3, 4'd8, 1'b0, 1'b1, 1'b1);
    send(2'b01, 4'd1, 4'd9, 1'b0, 1'b0, 1'b1);
    send(2'b00, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0);
    send(2'b10, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
    send(2'b01, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
    send(2'b01, 4'd1, 4'd8, 1'b0, 1'b1, 1'b1);
    send(2'b11, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0);
    send(2'b00, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    send(2'b01, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0);
    send(2'b00, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
    send(2'b10, 4'd7, 4'd13, 1'b0, 1'b0, 1'b0);
    // backpressure on ADD result 9
    send(2'b00, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
    send(2'b01, 4'd5, 4'd9, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_op = 2'b11;
    in_data = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 8'(in_ready), 8'd0);
      check("stall_acc", 8'(acc), 8'd9);
      check("stall_out_valid", 8'(out_valid), 8'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    push(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("release_in_ready", 8'(in_ready), 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_accept_acc", 8'(acc), 8'd0);
    // back-to-back ADD 1 from zero
    for (int i = 1; i <= 4; i++) begin
      send(2'b01, 4'd1, 4'(i), 1'b0, 1'b0, 1'b0);
      if (i > 1) check("b2b_out_valid", 8'(out_valid), 8'd1);
    end
    while (cnt_m != 8'd255) send(2'b11, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    send(2'b11, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("count_wrap", op_count, 8'd0);
    // asynchronous reset while a result is pending
    send(2'b00, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 8'(out_valid), 8'd0);
    check("async_rst_acc", 8'(acc), 8'd0);
    check("async_rst_zero", 8'(zero), 8'd1);
    q.delete();
    cnt_m = '0;
    #10;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(2'b00, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
